// File: rtl/serial_adder_pkg.sv
// Shared state encodings for the serial arithmetic sequencers
// (serial adder today; serial multiplier/shift sequencers later).
package serial_adder_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// 1-bit full adder cell built from two half adders plus an OR for the carry.
// This is the shared 1-bit datapath sequenced by serial_adder_ctrl.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (.x(a),  .y(b),   .s(s1), .c(c1));
  half_adder u_ha1 (.x(s1), .y(cin), .s(s),  .c(c2));

  assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller: captures operands on start, then
// feeds them LSB-first through one fa_bit cell over WIDTH cycles.
// Optional macro SERIAL_SUB_EN adds a 'sub' port for two's-complement a-b.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               s_bit;
  logic               c_bit;
  logic               accept;
  logic               cnt_last;
  logic [WIDTH-1:0]   b_init;
  logic               carry_init;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign cnt_last = (cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_SUB_EN
  // Subtraction as a + ~b + 1: invert B and seed the carry with 1.
  assign b_init     = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_init     = b;
  assign carry_init = 1'b0;
`endif

  fa_bit u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (s_bit),
    .cout(c_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; unknown encodings fall back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? SHIFT : IDLE;
      SHIFT:   state_nxt = cnt_last ? DONE : SHIFT;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, bit-serial shifting and result commit on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b_init;
      acc   <= '0;
      cnt   <= '0;
      carry <= carry_init;
    end else if (state == SHIFT) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      acc   <= {s_bit, acc[WIDTH-1:1]};
      carry <= c_bit;
      cnt   <= cnt + 1'b1;
      if (cnt_last) begin
        sum  <= {s_bit, acc[WIDTH-1:1]};
        cout <= c_bit;
      end
    end
  end

  // Handshake outputs decoded from the registered state.
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8) with a scoreboard queue.
// Define SERIAL_SUB_EN for both RTL and bench to exercise subtraction.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         done;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
`ifdef SERIAL_SUB_EN
    .sub  (sub),
`endif
    .sum  (sum),
    .cout (cout),
    .busy (busy),
    .done (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one start cycle and push the reference result; returns at the
  // negedge following the accepting posedge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
    logic [W:0] r;
    exp_t e;
    @(negedge clk);
    a = ia; b = ib; sub = isub; start = 1'b1;
    if (isub) r = {1'b0, ia} + {1'b0, ~ib} + 1'b1;
    else      r = {1'b0, ia} + {1'b0, ib};
    e.s = r[W-1:0];
    e.c = r[W];
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, counting busy cycles and checking that the
  // previous result is held meanwhile; then compare against the scoreboard.
  task automatic wait_done(input string tag, input int pre,
                           input logic [W-1:0] psum, input logic pcout);
    int   n = pre;
    logic held = 1'b1;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      if (busy) n++;
      if (sum !== psum || cout !== pcout) held = 1'b0;
      @(negedge clk);
    end
    check({tag, " done"}, done, 1'b1);
    check({tag, " busy_cycles"}, n, W);
    check({tag, " held"}, held, 1'b1);
    check({tag, " busy_in_done"}, busy, 1'b0);
    if (q.size() > 0) begin
      e = q.pop_front();
      check({tag, " sum"}, sum, e.s);
      check({tag, " cout"}, cout, e.c);
    end else begin
      check({tag, " scoreboard_empty"}, q.size(), 1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    @(negedge clk);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: basic add, done is a single-cycle pulse
    issue(8'h35, 8'h4A, 1'b0);
    wait_done("t1", 0, 8'h00, 1'b0);
    @(negedge clk);
    check("t1 done_pulse", done, 0);
    check("t1 idle_busy", busy, 0);

    // 2: overflow wraps, carry out set, previous sum held until final bit
    issue(8'hFF, 8'h01, 1'b0);
    wait_done("t2", 0, 8'h7F, 1'b0);

    // 3: start during SHIFT is ignored
    issue(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 8'h00; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t3", 3, 8'h00, 1'b1);

    // 4: async reset mid-SHIFT aborts immediately
    issue(8'hAA, 8'h11, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4 rst busy", busy, 0);
    check("t4 rst done", done, 0);
    check("t4 rst sum", sum, 0);
    check("t4 rst cout", cout, 0);
    void'(q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    issue(8'h01, 8'h01, 1'b0);
    wait_done("t4", 0, 8'h00, 1'b0);

    // 5: back-to-back start accepted in DONE
    issue(8'h03, 8'h04, 1'b0);
    wait_done("t5a", 0, 8'h02, 1'b0);
    a = 8'h10; b = 8'h20; start = 1'b1;
    begin
      exp_t e;
      e.s = 8'h30; e.c = 1'b0;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    check("t5 done_low", done, 0);
    check("t5 busy_again", busy, 1);
    wait_done("t5b", 0, 8'h07, 1'b0);

    // extra: 0x80 + 0x80 wraps to zero with carry
    issue(8'h80, 8'h80, 1'b0);
    wait_done("ovf", 0, 8'h30, 1'b0);

`ifdef SERIAL_SUB_EN
    // 6: subtraction, cout = no-borrow
    issue(8'h10, 8'h01, 1'b1);
    wait_done("t6a", 0, 8'h00, 1'b1);
    issue(8'h01, 8'h02, 1'b1);
    wait_done("t6b", 0, 8'h0F, 1'b1);
    issue(8'h05, 8'h03, 1'b0);
    wait_done("t6c", 0, 8'hFF, 1'b0);
`endif

    check("scoreboard drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
